// File: rtl/eth_pkg.sv
// Shared Ethernet datapath types used by the RMII buffer, bit-order and CRC stages.
package eth_pkg;

  localparam int DIBITS_PER_BYTE = 4;

  typedef logic [1:0] dibit_t;
  typedef logic [$clog2(DIBITS_PER_BYTE)-1:0] phase_t;

endpackage

// File: rtl/bitorder.sv
// Reorders MSb-first input dibits into LSb-first RMII dibits with a fixed
// 4-cycle latency, using two byte-wide ping-pong banks.
module bitorder
  import eth_pkg::*;
#(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             axiiv,
  input  logic [1:0]       axiid,
  output logic             axiov,
  output logic [1:0]       axiod,
  output logic             pkt_done,
  output logic [CNT_W-1:0] byte_cnt,
  output logic             err_partial
);

  localparam phase_t LAST_PHASE = phase_t'(DIBITS_PER_BYTE - 1);

  phase_t             phase_q, phase_d;
  logic               sync_q, sync_d;
  logic [7:0]         bank_q [2];
  logic [7:0]         bank_d [2];
  logic               wr_sel_q, wr_sel_d;
  logic               rd_sel_q, rd_sel_d;
  phase_t             drain_q, drain_d;
  phase_t             drain_idx;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               axiov_q, axiov_d;
  dibit_t             axiod_q, axiod_d;
  logic               pkt_done_q, pkt_done_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic               valid_in;

  // Input is only accepted once axiiv has been seen low since the last reset.
  assign valid_in = axiiv & sync_q & ~rst;

  always_comb begin
    phase_d    = '0;
    sync_d     = sync_q | ~axiiv;
    bank_d     = bank_q;
    wr_sel_d   = wr_sel_q;
    rd_sel_d   = rd_sel_q;
    drain_d    = drain_q;
    cnt_d      = cnt_q;
    axiov_d    = 1'b0;
    axiod_d    = '0;
    drain_idx  = phase_t'(2'd0 - drain_q);

    if (valid_in) begin
      bank_d[wr_sel_q][{~phase_q, 1'b0} +: 2] = axiid;
      phase_d = phase_q + 2'd1;
    end

    // The last dibit of a byte is byte[1:0], so it goes straight out while the
    // remaining three dibits drain from the bank it just completed.
    if (valid_in && phase_q == LAST_PHASE) begin
      axiov_d  = 1'b1;
      axiod_d  = axiid;
      drain_d  = phase_t'(DIBITS_PER_BYTE - 1);
      rd_sel_d = wr_sel_q;
      wr_sel_d = ~wr_sel_q;
      if (!axiov_q)
        cnt_d = CNT_W'(1);
      else if (cnt_q != {CNT_W{1'b1}})
        cnt_d = cnt_q + CNT_W'(1);
    end else if (drain_q != '0) begin
      axiov_d = 1'b1;
      axiod_d = bank_q[rd_sel_q][{drain_idx, 1'b0} +: 2];
      drain_d = drain_q - 2'd1;
    end

    pkt_done_d = axiov_q & ~axiov_d;
    byte_cnt_d = pkt_done_d ? cnt_q : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= '0;
      sync_q     <= 1'b0;
      bank_q[0]  <= '0;
      bank_q[1]  <= '0;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      drain_q    <= '0;
      cnt_q      <= '0;
      axiov_q    <= 1'b0;
      axiod_q    <= '0;
      pkt_done_q <= 1'b0;
      byte_cnt_q <= '0;
    end else begin
      phase_q    <= phase_d;
      sync_q     <= sync_d;
      bank_q     <= bank_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      drain_q    <= drain_d;
      cnt_q      <= cnt_d;
      axiov_q    <= axiov_d;
      axiod_q    <= axiod_d;
      pkt_done_q <= pkt_done_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  assign axiov       = axiov_q;
  assign axiod       = axiod_q;
  assign pkt_done    = pkt_done_q;
  assign byte_cnt    = byte_cnt_q;
  // Flagged on the first low input cycle, before the phase is cleared.
  assign err_partial = ~rst & ~axiiv & (phase_q != '0);

endmodule

// File: tb/tb_bitorder.sv
// Randomised and directed bench for bitorder, checked against a packet-level
// model built from the input stream before the run starts.
module tb_bitorder;

  localparam int TB_CNT_W = 4;
  localparam int SAT      = (1 << TB_CNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                axiiv;
  logic [1:0]          axiid;
  logic                axiov;
  logic [1:0]          axiod;
  logic                pkt_done;
  logic [TB_CNT_W-1:0] byte_cnt;
  logic                err_partial;

  bitorder #(.CNT_W(TB_CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .axiiv       (axiiv),
    .axiid       (axiid),
    .axiov       (axiov),
    .axiod       (axiod),
    .pkt_done    (pkt_done),
    .byte_cnt    (byte_cnt),
    .err_partial (err_partial)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  bit         sRst[$];
  bit         sV[$];
  logic [1:0] sD[$];

  int eV[], eD[], eDone[], eCnt[], eErr[];
  logic [31:0] oV[], oD[], oDone[], oCnt[], oErr[];

  task automatic push(input bit r, input bit v, input logic [1:0] d);
    sRst.push_back(r);
    sV.push_back(v);
    sD.push_back(d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'b0, 2'd0);
  endtask

  task automatic sendByte(input logic [7:0] b);
    for (int i = 3; i >= 0; i--) push(1'b0, 1'b1, b[2*i +: 2]);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int c);
    rst   = sRst[c];
    axiiv = sV[c];
    axiid = sD[c];
  endtask

  // Build the expected waveforms from packet-level rules: find valid runs,
  // place each whole byte reversed 4..7 cycles after its first dibit.
  task automatic buildModel(input int n);
    bit sync;
    bit valid[];
    int c, s, len, runLen;
    eV = new[n]; eD = new[n]; eDone = new[n]; eCnt = new[n]; eErr = new[n];
    valid = new[n];
    sync = 1'b0;
    for (int t = 0; t < n; t++) begin
      valid[t] = sV[t] && sync && !sRst[t];
      if (sRst[t]) sync = 1'b0;
      else if (!sV[t]) sync = 1'b1;
    end
    c = 0;
    while (c < n) begin
      if (valid[c]) begin
        s = c;
        while (c < n && valid[c]) c++;
        len = c - s;
        for (int k = 0; k < len / 4; k++) begin
          for (int j = 0; j < 4; j++) begin
            int st, t;
            bit killed;
            st = s + 4 * k;
            t  = st + 4 + j;
            killed = 1'b0;
            for (int r = st; r < t; r++) if (sRst[r]) killed = 1'b1;
            if (!killed && t < n) begin
              eV[t] = 1;
              eD[t] = int'(sD[st + 3 - j]);
            end
          end
        end
        if ((len % 4) != 0 && c < n && !sRst[c]) eErr[c] = 1;
      end else begin
        c++;
      end
    end
    runLen = 0;
    for (int t = 1; t < n; t++) begin
      if (eV[t-1] != 0) runLen++;
      else runLen = 0;
      if (eV[t-1] != 0 && eV[t] == 0 && !sRst[t-1]) begin
        eDone[t] = 1;
        eCnt[t]  = (runLen / 4 > SAT) ? SAT : runLen / 4;
      end
    end
  endtask

  int sA, sB, sC, sD0, sE, sE2, sF, sS, n;

  initial begin
    logic [7:0] eBytes [4];
    logic [7:0] b;
    logic [1:0] expA [4];
    logic [1:0] expC [4];
    int acc, accDone;

    rst = 1'b1; axiiv = 1'b0; axiid = 2'd0;

    push(1'b1, 1'b0, 2'd0); push(1'b1, 1'b0, 2'd0); idle(3);
    sA = sRst.size(); sendByte(8'hD5); idle(8);
    sB = sRst.size();
    for (int i = 0; i < 7; i++) sendByte(8'h55);
    sendByte(8'hD5); idle(6);
    sC = sRst.size(); sendByte(8'hA7); push(1'b0, 1'b1, 2'd3); push(1'b0, 1'b1, 2'd3); idle(8);
    sD0 = sRst.size(); sendByte(8'h11); sendByte(8'h22); idle(1);
    sendByte(8'h33); sendByte(8'h44); idle(8);
    sE = sRst.size();
    eBytes[0] = 8'h12; eBytes[1] = 8'h34; eBytes[2] = 8'h56; eBytes[3] = 8'h78;
    for (int i = 0; i < 16; i++) begin
      b = eBytes[i/4];
      push(i == 5, 1'b1, b[2*(3 - i%4) +: 2]);
    end
    idle(1);
    sE2 = sRst.size(); sendByte(8'h9C); sendByte(8'hE1); idle(8);
    sF = sRst.size(); push(1'b0, 1'b1, 2'd2); push(1'b0, 1'b1, 2'd1); push(1'b0, 1'b1, 2'd3); idle(8);
    sS = sRst.size();
    for (int i = 0; i < 20; i++) sendByte(8'($urandom));
    idle(8);
    for (int p = 0; p < 40; p++) begin
      int len, rpos;
      len  = int'($urandom_range(1, 40));
      rpos = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      for (int i = 0; i < len; i++) push(i == rpos, 1'b1, 2'($urandom_range(0, 3)));
      idle(int'($urandom_range(1, 4)));
    end
    idle(12);

    n = sRst.size();
    buildModel(n);
    oV = new[n]; oD = new[n]; oDone = new[n]; oCnt = new[n]; oErr = new[n];

    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1 applyStimulus(c);
      @(negedge clk);
      oV[c] = 32'(axiov); oD[c] = 32'(axiod); oDone[c] = 32'(pkt_done);
      oCnt[c] = 32'(byte_cnt); oErr[c] = 32'(err_partial);
      if (c >= 1) begin
        checkOutput($sformatf("axiov@%0d", c), oV[c], eV[c]);
        checkOutput($sformatf("axiod@%0d", c), oD[c], eD[c]);
        checkOutput($sformatf("pkt_done@%0d", c), oDone[c], eDone[c]);
        checkOutput($sformatf("err_partial@%0d", c), oErr[c], eErr[c]);
        if (eDone[c] != 0) checkOutput($sformatf("byte_cnt@%0d", c), oCnt[c], eCnt[c]);
      end
    end
    @(posedge clk);

    checkOutput("reset_axiov", oV[1], 0);
    checkOutput("reset_byte_cnt", oCnt[1], 0);

    expA[0] = 2'd1; expA[1] = 2'd1; expA[2] = 2'd1; expA[3] = 2'd3;
    for (int j = 0; j < 4; j++) checkOutput($sformatf("sfd_dibit%0d", j), oD[sA + 4 + j], 32'(expA[j]));
    checkOutput("sfd_done", oDone[sA + 8], 1);
    checkOutput("sfd_cnt", oCnt[sA + 8], 1);

    acc = 0;
    for (int t = sB + 4; t < sB + 36; t++) acc += int'(oV[t]);
    checkOutput("preamble_run", 32'(acc), 32);
    for (int j = 0; j < 4; j++) checkOutput($sformatf("preamble_sfd%0d", j), oD[sB + 32 + j], 32'(expA[j]));
    checkOutput("preamble_cnt", oCnt[sB + 36], 8);

    expC[0] = 2'd3; expC[1] = 2'd1; expC[2] = 2'd2; expC[3] = 2'd2;
    for (int j = 0; j < 4; j++) checkOutput($sformatf("partial_dibit%0d", j), oD[sC + 4 + j], 32'(expC[j]));
    checkOutput("partial_err", oErr[sC + 6], 1);
    checkOutput("partial_cnt", oCnt[sC + 8], 1);

    checkOutput("gap_low", oV[sD0 + 12], 0);
    checkOutput("gap_second_start", oV[sD0 + 13], 1);
    checkOutput("gap_cnt1", oCnt[sD0 + 12], 2);
    checkOutput("gap_cnt2", oCnt[sD0 + 21], 2);

    acc = 0; accDone = 0;
    for (int t = sE + 6; t < sE2 + 4; t++) begin
      acc += int'(oV[t]);
      accDone += int'(oDone[t]) + int'(oErr[t]);
    end
    checkOutput("rst_quiet_axiov", 32'(acc), 0);
    checkOutput("rst_quiet_pulses", 32'(accDone), 0);
    checkOutput("rst_next_cnt", oCnt[sE2 + 12], 2);

    acc = 0;
    for (int t = sF; t < sF + 10; t++) acc += int'(oV[t]) + int'(oDone[t]);
    checkOutput("short_quiet", 32'(acc), 0);
    checkOutput("short_err", oErr[sF + 3], 1);

    checkOutput("saturate_cnt", oCnt[sS + 84], SAT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
